// File: rtl/alu_issue_queue.sv
// Operand FIFO between decode/operand-fetch and the ALU; presents the head {A, B, ALUOp}.
// Optional ALU_OPCHECK_EN: drop pushes carrying opcode 6/7 and pulse err_illegal.
module alu_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_A,
    input  logic [31:0]      in_B,
    input  logic [2:0]       in_ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic [2:0]       ALUOp,
    output logic [PTR_W:0]   count,
    output logic             err_illegal
);

    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

    logic [66:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop, legal, wr_en;
    logic [66:0]      head;

`ifdef ALU_OPCHECK_EN
    logic err_q;
    assign legal = (in_ALUOp < 3'd6);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= push & ~legal;
        end
    end
    assign err_illegal = err_q;
`else
    assign legal       = 1'b1;
    assign err_illegal = 1'b0;
`endif

    assign in_ready  = (count_q != FullCnt);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // An illegal push completes its handshake but leaves no trace in the queue.
    assign wr_en     = push & legal;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {in_A, in_B, in_ALUOp};
        end
    end

    // Empty queue shows 0 + 0 with op 0 to the ALU.
    assign head  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign A     = head[66:35];
    assign B     = head[34:3];
    assign ALUOp = head[2:0];
    assign count = count_q;

endmodule
